// File: rtl/afe_load_align_pipe.sv
// Load-path formatter: queues load descriptors, aligns and merges memory beats,
// and presents the registered, zero/sign-extended result under valid/busy.
//
// Ports:
//   iCLOCK, inRESET (async, active low), iRESET_SYNC (sync clear)
//   iREQ_VALID/oREQ_BUSY, iREQ_AFE_CODE, iREQ_OFFSET : descriptor push
//   iMEM_VALID/oMEM_BUSY, iMEM_DATA                  : memory beats
//   oDATA_VALID/iDATA_BUSY, oDATA, oDATA_SPLIT       : formatted result
module afe_load_align_pipe #(
  parameter  int DATA_N     = 32,
  parameter  int DESC_DEPTH = 4,
  localparam int OFS_N      = $clog2(DATA_N/8)
) (
  input  logic              iCLOCK,
  input  logic              inRESET,
  input  logic              iRESET_SYNC,
  input  logic              iREQ_VALID,
  output logic              oREQ_BUSY,
  input  logic [3:0]        iREQ_AFE_CODE,
  input  logic [OFS_N-1:0]  iREQ_OFFSET,
  input  logic              iMEM_VALID,
  output logic              oMEM_BUSY,
  input  logic [DATA_N-1:0] iMEM_DATA,
  output logic              oDATA_VALID,
  input  logic              iDATA_BUSY,
  output logic [DATA_N-1:0] oDATA,
  output logic              oDATA_SPLIT
);

  localparam int NB = DATA_N/8;
  localparam int PW = $clog2(DESC_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(DATA_N) + 1;

  typedef struct packed {
    logic [3:0]       code;
    logic [OFS_N-1:0] ofs;
    logic             split;
  } desc_t;

  typedef enum logic {IDLE, SECOND} state_t;

  function automatic logic [OFS_N:0] size_of(input logic [3:0] c);
    logic [OFS_N:0] s;
    s = (OFS_N+1)'(NB);
    unique case (c)
      4'd1, 4'd3: s = (OFS_N+1)'(1);
      4'd2, 4'd4: s = (OFS_N+1)'(2);
      4'd5, 4'd6: if (DATA_N > 32) s = (OFS_N+1)'(4);
      default: ;
    endcase
    return s;
  endfunction

  desc_t             fifo_q [DESC_DEPTH];
  logic [PW-1:0]     wp_q, rp_q;
  logic [CW-1:0]     cnt_q;
  state_t            state_q, state_d;
  logic [DATA_N-1:0] hold_q, hold_d;
  logic              vld_q;
  logic [DATA_N-1:0] dat_q;
  logic              spl_q;

  desc_t             req_desc, head;
  logic [OFS_N+1:0]  span;
  logic              full, empty, stall;
  logic              push, pop, beat_acc;
  logic [DATA_N-1:0] lo, hi;

  assign span = (OFS_N+2)'(iREQ_OFFSET)
              + (OFS_N+2)'(size_of(iREQ_AFE_CODE));
  assign req_desc.code  = iREQ_AFE_CODE;
  assign req_desc.ofs   = iREQ_OFFSET;
  assign req_desc.split = span > (OFS_N+2)'(NB);

  assign full      = cnt_q == CW'(DESC_DEPTH);
  assign empty     = cnt_q == '0;
  assign stall     = vld_q && iDATA_BUSY;
  assign oREQ_BUSY = full;
  assign oMEM_BUSY = empty || stall;
  assign push      = iREQ_VALID && !full;
  assign beat_acc  = iMEM_VALID && !oMEM_BUSY;
  assign head      = fifo_q[rp_q];

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    pop     = 1'b0;
    lo      = iMEM_DATA;
    hi      = '0;
    unique case (state_q)
      IDLE: begin
        if (beat_acc) begin
          if (head.split) begin
            hold_d  = iMEM_DATA;
            state_d = SECOND;
          end else begin
            pop = 1'b1;
          end
        end
      end
      SECOND: begin
        lo = hold_q;
        hi = iMEM_DATA;
        if (beat_acc) begin
          pop     = 1'b1;
          hold_d  = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Right-justify the datum, then push it to the top and shift it
  // back down so the fill bits come from bit 8S-1 (or zeros).
  logic [DATA_N-1:0]        raw, tmp, zres, sres, res;
  logic signed [DATA_N-1:0] stmp;
  logic [OFS_N:0]           hsz;
  logic [SW-1:0]            sh;
  logic                     sx;

  assign raw  = DATA_N'({hi, lo} >> {head.ofs, 3'b000});
  assign hsz  = size_of(head.code);
  assign sh   = SW'(DATA_N) - SW'({hsz, 3'b000});
  assign sx   = (head.code == 4'd1) || (head.code == 4'd2)
             || ((head.code == 4'd5) && (DATA_N > 32));
  assign tmp  = raw << sh;
  assign stmp = tmp;
  assign sres = stmp >>> sh;
  assign zres = tmp >> sh;
  assign res  = sx ? sres : zres;

  always_ff @(posedge iCLOCK) begin
    if (push) fifo_q[wp_q] <= req_desc;
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      state_q <= IDLE;
      hold_q  <= '0;
      vld_q   <= 1'b0;
      dat_q   <= '0;
      spl_q   <= 1'b0;
    end else if (iRESET_SYNC) begin
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      state_q <= IDLE;
      hold_q  <= '0;
      vld_q   <= 1'b0;
      dat_q   <= '0;
      spl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      if (push) wp_q <= wp_q + PW'(1);
      if (pop)  rp_q <= rp_q + PW'(1);
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: ;
      endcase
      // A finishing beat is only accepted when the output is free
      // or draining this cycle, so load wins over drain.
      if (pop) begin
        vld_q <= 1'b1;
        dat_q <= res;
        spl_q <= head.split;
      end else if (!iDATA_BUSY) begin
        vld_q <= 1'b0;
      end
    end
  end

  assign oDATA_VALID = vld_q;
  assign oDATA       = dat_q;
  assign oDATA_SPLIT = spl_q;

endmodule

// File: tb/tb_afe_load_align_pipe.sv
// Bench for afe_load_align_pipe: directed cases plus random traffic
// checked against a queue-based byte-level reference model.
module tb_afe_load_align_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, srst, rv, mv, db;
  logic [3:0]  code;
  logic [1:0]  ofs;
  logic [31:0] md;
  logic        req_busy, mem_busy, dvalid, dsplit;
  logic [31:0] dout;

  logic        w_rv, w_mv, w_db;
  logic [3:0]  w_code;
  logic [2:0]  w_ofs;
  logic [63:0] w_md, w_dout;
  logic        w_req_busy, w_mem_busy, w_dvalid, w_dsplit;

  afe_load_align_pipe #(.DATA_N(32), .DESC_DEPTH(4)) dut (
    .iCLOCK(clk), .inRESET(rst_n), .iRESET_SYNC(srst),
    .iREQ_VALID(rv), .oREQ_BUSY(req_busy),
    .iREQ_AFE_CODE(code), .iREQ_OFFSET(ofs),
    .iMEM_VALID(mv), .oMEM_BUSY(mem_busy), .iMEM_DATA(md),
    .oDATA_VALID(dvalid), .iDATA_BUSY(db),
    .oDATA(dout), .oDATA_SPLIT(dsplit)
  );

  afe_load_align_pipe #(.DATA_N(64), .DESC_DEPTH(4)) dut64 (
    .iCLOCK(clk), .inRESET(rst_n), .iRESET_SYNC(1'b0),
    .iREQ_VALID(w_rv), .oREQ_BUSY(w_req_busy),
    .iREQ_AFE_CODE(w_code), .iREQ_OFFSET(w_ofs),
    .iMEM_VALID(w_mv), .oMEM_BUSY(w_mem_busy), .iMEM_DATA(w_md),
    .oDATA_VALID(w_dvalid), .iDATA_BUSY(w_db),
    .oDATA(w_dout), .oDATA_SPLIT(w_dsplit)
  );

  typedef struct { logic [3:0] c; int o; } desc_t;
  typedef struct { logic [31:0] d; bit s; } res_t;

  desc_t       dq[$];
  res_t        eq[$];
  logic [31:0] part[$];
  int errs = 0;
  int checks = 0;
  int drained = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sz(input logic [3:0] c);
    case (c)
      4'd1, 4'd3: return 1;
      4'd2, 4'd4: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic bit two(input desc_t d);
    return (d.o + sz(d.c)) > 4;
  endfunction

  function automatic res_t fmt(input desc_t d, input logic [31:0] b0,
                               input logic [31:0] b1);
    logic [7:0]  by [8];
    logic [31:0] v;
    res_t        r;
    int          s;
    for (int i = 0; i < 4; i++) begin
      by[i]   = b0[8*i +: 8];
      by[i+4] = b1[8*i +: 8];
    end
    s = sz(d.c);
    v = '0;
    for (int i = 0; i < s; i++) v[8*i +: 8] = by[d.o + i];
    if ((d.c == 4'd1 || d.c == 4'd2) && v[8*s-1])
      for (int i = s; i < 4; i++) v[8*i +: 8] = 8'hFF;
    r.d = v;
    r.s = two(d);
    return r;
  endfunction

  task automatic clear_model();
    dq.delete();
    eq.delete();
    part.delete();
  endtask

  task automatic step(input bit r, input logic [3:0] c,
                      input logic [1:0] o, input bit m,
                      input logic [31:0] d, input bit b,
                      input bit sr = 1'b0);
    bit racc, macc, stl;
    @(negedge clk);
    rv = r; code = c; ofs = o; mv = m; md = d; db = b; srst = sr;
    #1;
    stl = (eq.size() != 0) && b;
    check("req_busy", req_busy, dq.size() == 4);
    check("mem_busy", mem_busy, (dq.size() == 0) || stl);
    check("valid", dvalid, eq.size() != 0);
    if (eq.size() != 0) begin
      check("data", dout, eq[0].d);
      check("split", dsplit, eq[0].s);
    end
    if (sr) begin
      clear_model();
      return;
    end
    racc = r && (dq.size() < 4);
    macc = m && (dq.size() != 0) && !stl;
    if (eq.size() != 0 && !b) begin
      void'(eq.pop_front());
      drained++;
    end
    if (macc) begin
      part.push_back(d);
      if (part.size() == (two(dq[0]) ? 2 : 1)) begin
        eq.push_back(fmt(dq[0], part[0],
                         part.size() > 1 ? part[1] : 32'h0));
        void'(dq.pop_front());
        part.delete();
      end
    end
    if (racc) dq.push_back('{c, int'(o)});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic async_rst();
    @(negedge clk);
    rv = 0; mv = 0; db = 0; srst = 0;
    rst_n = 1'b0;
    #1;
    clear_model();
    check("rst_valid", dvalid, 0);
    check("rst_data", dout, 0);
    check("rst_split", dsplit, 0);
    check("rst_mbusy", mem_busy, 1);
    check("rst_rbusy", req_busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int d0;
    rst_n = 0; srst = 0; rv = 0; mv = 0; db = 0;
    code = 0; ofs = 0; md = 0;
    w_rv = 0; w_mv = 0; w_db = 0; w_code = 0; w_ofs = 0; w_md = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;

    idle(1);
    check("init_data", dout, 0);
    check("init_mbusy", mem_busy, 1);

    step(1, 4'd1, 2'd3, 0, 0, 0);
    step(0, 0, 0, 1, 32'h80AABBCC, 0);
    idle(1);
    check("tp1_data", dout, 32'hFFFFFF80);
    check("tp1_split", dsplit, 0);
    idle(1);

    step(1, 4'd4, 2'd3, 0, 0, 0);
    step(0, 0, 0, 1, 32'h12345678, 0);
    check("tp2_mb1", mem_busy, 0);
    step(0, 0, 0, 1, 32'h9ABCDEF0, 0);
    check("tp2_mb2", mem_busy, 0);
    idle(1);
    check("tp2_data", dout, 32'h0000F012);
    check("tp2_split", dsplit, 1);
    idle(1);

    step(1, 4'd2, 2'd0, 0, 0, 0);
    step(1, 4'd3, 2'd1, 1, 32'h00008001, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1, 32'h11223344, 1);
      check("tp3_hold", dout, 32'hFFFF8001);
      check("tp3_vld", dvalid, 1);
      check("tp3_mb", mem_busy, 1);
    end
    step(0, 0, 0, 1, 32'h11223344, 0);
    idle(1);
    check("tp3_next", dout, 32'h00000033);
    idle(1);

    d0 = drained;
    for (int i = 0; i < 4; i++) step(1, 4'd0, 2'd0, 0, 0, 0);
    step(1, 4'd0, 2'd0, 0, 0, 0);
    check("tp4_full", req_busy, 1);
    step(1, 4'd0, 2'd0, 1, $urandom, 0);
    check("tp4_full2", req_busy, 1);
    step(1, 4'd0, 2'd0, 1, $urandom, 0);
    check("tp4_free", req_busy, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, $urandom, 0);
    idle(2);
    check("tp4_count", drained - d0, 5);

    step(1, 4'd4, 2'd3, 0, 0, 0);
    step(0, 0, 0, 1, 32'h12345678, 0);
    async_rst();
    idle(1);
    check("tp5_vld", dvalid, 0);
    step(1, 4'd1, 2'd0, 0, 0, 0);
    step(0, 0, 0, 1, 32'h000000F0, 0);
    idle(1);
    check("tp5_data", dout, 32'hFFFFFFF0);

    step(1, 4'd4, 2'd3, 0, 0, 0);
    step(0, 0, 0, 1, 32'h12345678, 0);
    step(0, 0, 0, 1, 32'h9ABCDEF0, 0, 1'b1);
    idle(1);
    check("srst_vld", dvalid, 0);
    check("srst_mb", mem_busy, 1);

    for (int i = 0; i < 4000; i++)
      step($urandom_range(0, 2) == 0, 4'($urandom), 2'($urandom),
           $urandom_range(0, 1) == 1, $urandom,
           $urandom_range(0, 3) == 0, $urandom_range(0, 499) == 0);
    for (int i = 0; i < 12; i++) step(0, 0, 0, 1, $urandom, 0);
    idle(2);
    check("rand_drain", eq.size() + dq.size(), 0);

    @(negedge clk);
    w_rv = 1; w_code = 4'd5; w_ofs = 3'd6;
    @(negedge clk);
    w_rv = 0; w_mv = 1; w_md = 64'hFFEE_0000_0000_0000;
    #1 check("w_mb1", w_mem_busy, 0);
    @(negedge clk);
    w_md = 64'h0000_0000_0000_8899;
    #1 check("w_mb2", w_mem_busy, 0);
    @(negedge clk);
    w_mv = 0;
    #1;
    check("w_vld", w_dvalid, 1);
    check("w_data", w_dout, 64'hFFFFFFFF_8899FFEE);
    check("w_split", w_dsplit, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/afe_load_align_pipe.md
Name: afe_load_align_pipe

Overview:
- Load-path data formatter between the data-memory response port and register writeback.
- Successor to the combinational load AFE, parametrised in data width and descriptor queue depth.
- Adds zero extension, byte-offset alignment, and two-beat merging for loads that cross a bus-word boundary.
- Queues load descriptors issued by the LSU, consumes memory beats in order, and presents the registered, extended result under a valid/busy handshake.

Parameters:
- DATA_N, 32, bus/result width in bits; legal values are 32 and 64.
- DESC_DEPTH, 4, descriptor FIFO entries; power of two, at least 2.
- OFS_N, derived log2(DATA_N/8), byte-offset width; not user-set.

Ports:
- iCLOCK  in  1  clock.
- inRESET  in  1  asynchronous active-low reset.
- iRESET_SYNC  in  1  synchronous clear, same effect as reset.
- iREQ_VALID  in  1  load descriptor valid.
- oREQ_BUSY  out  1  descriptor FIFO full; request not accepted.
- iREQ_AFE_CODE  in  4  extension/size code.
- iREQ_OFFSET  in  OFS_N  byte offset of the datum within the first bus word.
- iMEM_VALID  in  1  memory data beat valid.
- oMEM_BUSY  out  1  beat not accepted this cycle.
- iMEM_DATA  in  DATA_N  memory beat.
- oDATA_VALID  out  1  result valid.
- iDATA_BUSY  in  1  writeback stall.
- oDATA  out  DATA_N  formatted result.
- oDATA_SPLIT  out  1  result was merged from two beats.

Behaviour:
- Codes and sizes:
  - 0 = NONE, full width. 1 = SEXT8. 2 = SEXT16. 3 = ZEXT8. 4 = ZEXT16.
  - 5 = SEXT32 and 6 = ZEXT32; both behave as NONE when DATA_N=32.
  - All other codes behave as NONE.
  - Size S bytes: 1 for codes 1/3, 2 for 2/4, 4 for 5/6, DATA_N/8 otherwise.
- Byte lanes: lane k = bits [8k+7:8k].
- Span: a load needs two beats when OFFSET+S > DATA_N/8. For NONE, any nonzero offset needs two beats.
- Datum assembly:
  - The first beat supplies lanes OFFSET..DATA_N/8-1 as the datum's low bytes.
  - The second beat supplies lanes 0.. as the datum's remaining high bytes.
  - The datum is right-justified in oDATA, then sign- or zero-extended from bit 8S-1.
- Request accept: iREQ_VALID && !oREQ_BUSY.
  - Push {code, offset, split} into the FIFO.
  - oREQ_BUSY = FIFO full, with no same-cycle push/pop bypass.
- Beat accept: iMEM_VALID && !oMEM_BUSY.
  - oMEM_BUSY = FIFO empty || (oDATA_VALID && iDATA_BUSY).
  - A descriptor and its first beat arriving in the same cycle into an empty FIFO: the beat stalls one cycle.
- FSM states:
  - IDLE: on an accepted beat, if the head descriptor needs one beat, load the output register and pop the FIFO; stay IDLE. If it needs two beats, capture the beat into a hold register and go to SECOND.
  - SECOND: on an accepted beat, merge with the hold register, load the output register, pop the FIFO, and return to IDLE.
- Output register:
  - Loads one cycle after the final beat is accepted, so single-beat latency is 1 clock.
  - oDATA_VALID is held, with oDATA stable, until a cycle with !iDATA_BUSY.
  - A new load and a drain may occur in the same cycle, giving back-to-back throughput of 1 per clock for single-beat loads.
- Reset (inRESET low, asynchronous, or iRESET_SYNC high at the clock edge):
  - FIFO emptied, FSM to IDLE, hold register cleared.
  - oDATA_VALID=0, oDATA=0, oDATA_SPLIT=0.
  - oREQ_BUSY=0 and oMEM_BUSY=1 (FIFO empty).
  - A half-merged load is discarded; no partial result is ever emitted.
- FIFO pointers wrap modulo DESC_DEPTH. Occupancy counts from 0 to DESC_DEPTH.

Test Plan:
- DATA_N=32, code 1, offset 3, beat 0x80AABBCC -> next cycle oDATA=0xFFFFFF80, oDATA_SPLIT=0.
- Code 4, offset 3, beats 0x12345678 then 0x9ABCDEF0 -> oDATA=0x0000F012, oDATA_SPLIT=1; oMEM_BUSY=0 on both beats.
- Code 2, offset 0, beat 0x00008001 with iDATA_BUSY held high for 3 cycles -> oDATA=0xFFFF8001 stable and valid for all 3 stalled cycles; next beat stalled via oMEM_BUSY=1.
- Push 4 descriptors without beats -> oREQ_BUSY=1 on the 5th request; one pop frees a slot next cycle; 5 results emerge in order.
- Reset asserted in SECOND after the first beat -> after release: oDATA_VALID=0, FIFO empty, next single-beat load produces a correct result.
- DATA_N=64, code 5, offset 6, beats 0xFFEE_0000_0000_0000 then 0x0000_0000_0000_8899 -> oDATA=0xFFFFFFFF_8899FFEE.
